wash_cycle_controller: RTL and testbench
========================================

# wash_cycle_controller

Sequencing FSM for the washing machine: steps through soak, wash, rinse and spin, driving the phase timer's `phase_sel`/`timer_start`/`timer_enable` inputs and consuming its `timer_done` output. It drives the fill valve, drain valve and motor for each phase. It pauses while the door is open, and a watchdog raises a sticky fault if the timer never completes a phase.

## Interface
- `WDOG_CYCLES`, default 1024: maximum enabled cycles per phase before fault; counter width is `$clog2(WDOG_CYCLES+1)`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_btn` in 1: level; requests a new cycle, accepted only in IDLE.
- `door_closed` in 1: 1 = door closed and latched.
- `timer_done` in 1: phase timer expiry, sampled only while `timer_enable`=1.
- `phase_sel` out 2: 00 soak, 01 wash, 10 rinse, 11 spin.
- `timer_start` out 1: one-cycle pulse at phase entry.
- `timer_enable` out 1: timer count enable.
- `fill_valve` out 1: water inlet.
- `drain_valve` out 1: water outlet.
- `motor_on` out 1: drum motor.
- `spin_fast` out 1: high-speed motor mode.
- `busy` out 1: cycle in progress (not IDLE, FAULT or DONE).
- `cycle_done` out 1: one-cycle completion pulse.
- `fault` out 1: sticky watchdog fault.

## Operation
- States: IDLE, ENTRY, RUN, PAUSE, DONE, FAULT. A phase register (2b) holds the current phase.
- IDLE → ENTRY when `start_btn`=1 and `door_closed`=1. The phase is set to soak, or to wash if soak is compiled out.
- ENTRY lasts one cycle: `timer_start`=1, `timer_enable`=0, watchdog cleared. Next state is RUN.
- RUN: `timer_enable`=1 and the watchdog increments each cycle.
  - On `timer_done`=1, the phase advances: soak→wash→rinse→spin, then next state is ENTRY.
  - If the current phase is spin, next state is DONE.
- Actuators are asserted in ENTRY, RUN and PAUSE-resume only, and are all 0 elsewhere:
  - soak: `fill_valve`.
  - wash: `motor_on`.
  - rinse: `fill_valve` + `motor_on`.
  - spin: `drain_valve` + `motor_on` + `spin_fast`.
- Door open in ENTRY or RUN → PAUSE. All actuators and `timer_enable` go to 0, and the watchdog is frozen.
  - `start_pending` is set if leaving ENTRY, or if `timer_done` coincided (phase already advanced).
  - PAUSE → ENTRY if `door_closed`=1 and `start_pending`; otherwise PAUSE → RUN, resuming the same phase without `timer_start`.
- `timer_done` in the same cycle as door open: advance takes priority. If the current phase is spin, go to DONE and ignore the door.
- Watchdog reaching `WDOG_CYCLES` in RUN without `timer_done` → FAULT. FAULT holds all outputs 0 except `fault`=1, and is left only via `rst_n`.
- DONE lasts one cycle: `cycle_done`=1, then IDLE. IDLE requires `start_btn` to be seen low before re-accepting, so a held button does not restart.
- `start_btn` is ignored outside IDLE.

## Timing
- All outputs are registered. Reset values: `phase_sel`=00, all other outputs 0; state IDLE, `start_pending`=0, watchdog 0.
- Latency:
  - `start_btn` accepted at edge N → `timer_start`=1 in cycle N+1, `timer_enable`=1 from N+2.
  - `timer_done` sampled at edge M → next phase `timer_start` at M+1.
- `phase_sel` changes in the same cycle `timer_start` rises and is stable for the whole phase, including PAUSE.
- `timer_start` and `timer_enable` are never high in the same cycle.
- Reset asserted mid-cycle: all outputs go to 0 immediately (asynchronously); there is no resume after reset.
- `timer_done` while `timer_enable`=0 is ignored.

## Configuration
- `WASH_CTRL_SOAK_EN` defined: cycle is soak→wash→rinse→spin.
- `WASH_CTRL_SOAK_EN` undefined: cycle starts at wash (`phase_sel`=01); phase 00 is never issued, and the soak actuator logic is removed.

## Test plan
- Full cycle with soak enabled and door closed, `timer_done` pulsed after 5 enabled cycles each phase → `phase_sel` 00,01,10,11, four `timer_start` pulses, then `cycle_done` for 1 cycle and `busy`=0.
- Door opens 3 cycles into wash, closes 10 cycles later → actuators 0 and `timer_enable`=0 for the 10 cycles, `phase_sel` stays 01, resume without `timer_start`.
- `timer_done` and door open in the same rinse cycle → `phase_sel`=11, PAUSE; on door close, `timer_start` pulses once, then `drain_valve`+`spin_fast` are asserted.
- `WDOG_CYCLES`=16, `timer_done` never asserted → `fault`=1 after 16 RUN cycles, all actuators 0, `start_btn` ignored until `rst_n`.
- `rst_n` low mid-spin → all outputs 0 asynchronously; after release, state IDLE and a held `start_btn` does not start a cycle until released and pressed again.
- Soak compiled out → first `timer_start` has `phase_sel`=01; three phases complete before `cycle_done`.

Source files
------------

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: sequences soak/wash/rinse/spin phases around an
// external phase timer, drives valves and motor, pauses on an open door and
// latches a sticky fault when a phase never completes.
// Optional feature: define WASH_CTRL_SOAK_EN to include the soak phase;
// without it the cycle starts at wash and the soak actuator decode is absent.
module wash_cycle_controller #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic [1:0] phase_sel,
    output logic       timer_start,
    output logic       timer_enable,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       spin_fast,
    output logic       busy,
    output logic       cycle_done,
    output logic       fault
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
    localparam logic [1:0] PH_SPIN = 2'b11;
`ifdef WASH_CTRL_SOAK_EN
    localparam logic [1:0] PH_FIRST = 2'b00;
`else
    localparam logic [1:0] PH_FIRST = 2'b01;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] phase_sel;
        logic       timer_start;
        logic       timer_enable;
        logic       fill_valve;
        logic       drain_valve;
        logic       motor_on;
        logic       spin_fast;
        logic       busy;
        logic       cycle_done;
        logic       fault;
    } outs_t;

    state_t            state_r;
    logic [1:0]        phase_r;
    logic [WDOG_W-1:0] wdog_r;
    logic              pending_r;
    logic              armed_r;
    outs_t             out_r;

    logic [1:0]        phase_nxt_s;
    logic [WDOG_W-1:0] wdog_inc_s;

    assign phase_nxt_s = phase_r + 2'b01;
    assign wdog_inc_s  = wdog_r + WDOG_W'(1);

    // Actuator pattern per phase: {fill, drain, motor, spin_fast}.
    function automatic logic [3:0] actuators_f(input logic [1:0] ph);
        logic [3:0] act;
        case (ph)
`ifdef WASH_CTRL_SOAK_EN
            2'b00:   act = 4'b1000;
`endif
            2'b01:   act = 4'b0010;
            2'b10:   act = 4'b1010;
            2'b11:   act = 4'b0111;
            default: act = 4'b0000;
        endcase
        return act;
    endfunction

    // Output word for the state being entered, so every output is a flop.
    function automatic outs_t outs_f(input state_t st, input logic [1:0] ph);
        outs_t o;
        logic [3:0] act;
        o   = '0;
        act = actuators_f(ph);
        case (st)
            ST_IDLE: begin
                o.phase_sel = ph;
            end
            ST_ENTRY: begin
                o.phase_sel   = ph;
                o.timer_start = 1'b1;
                {o.fill_valve, o.drain_valve, o.motor_on, o.spin_fast} = act;
                o.busy        = 1'b1;
            end
            ST_RUN: begin
                o.phase_sel    = ph;
                o.timer_enable = 1'b1;
                {o.fill_valve, o.drain_valve, o.motor_on, o.spin_fast} = act;
                o.busy         = 1'b1;
            end
            ST_PAUSE: begin
                o.phase_sel = ph;
                o.busy      = 1'b1;
            end
            ST_DONE: begin
                o.phase_sel  = ph;
                o.cycle_done = 1'b1;
            end
            ST_FAULT: begin
                o.fault = 1'b1;
            end
            default: begin
                o.fault = 1'b1;
            end
        endcase
        return o;
    endfunction

    // Sequencer: state, phase, watchdog, restart bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            phase_r   <= 2'b00;
            wdog_r    <= '0;
            pending_r <= 1'b0;
            armed_r   <= 1'b0;
            out_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_btn && door_closed && armed_r) begin
                        state_r <= ST_ENTRY;
                        phase_r <= PH_FIRST;
                        armed_r <= 1'b0;
                        out_r   <= outs_f(ST_ENTRY, PH_FIRST);
                    end else begin
                        // A held button must be released before it counts again.
                        armed_r <= armed_r | ~start_btn;
                        out_r   <= outs_f(ST_IDLE, phase_r);
                    end
                end
                ST_ENTRY: begin
                    wdog_r <= '0;
                    if (!door_closed) begin
                        state_r   <= ST_PAUSE;
                        pending_r <= 1'b1;
                        out_r     <= outs_f(ST_PAUSE, phase_r);
                    end else begin
                        state_r <= ST_RUN;
                        out_r   <= outs_f(ST_RUN, phase_r);
                    end
                end
                ST_RUN: begin
                    if (timer_done) begin
                        if (phase_r == PH_SPIN) begin
                            // Final phase completes even if the door opens now.
                            state_r <= ST_DONE;
                            out_r   <= outs_f(ST_DONE, phase_r);
                        end else if (!door_closed) begin
                            state_r   <= ST_PAUSE;
                            phase_r   <= phase_nxt_s;
                            pending_r <= 1'b1;
                            out_r     <= outs_f(ST_PAUSE, phase_nxt_s);
                        end else begin
                            state_r <= ST_ENTRY;
                            phase_r <= phase_nxt_s;
                            out_r   <= outs_f(ST_ENTRY, phase_nxt_s);
                        end
                    end else if (!door_closed) begin
                        state_r   <= ST_PAUSE;
                        pending_r <= 1'b0;
                        out_r     <= outs_f(ST_PAUSE, phase_r);
                    end else if (wdog_inc_s == WDOG_LIMIT) begin
                        state_r <= ST_FAULT;
                        out_r   <= outs_f(ST_FAULT, phase_r);
                    end else begin
                        wdog_r <= wdog_inc_s;
                        out_r  <= outs_f(ST_RUN, phase_r);
                    end
                end
                ST_PAUSE: begin
                    if (door_closed && pending_r) begin
                        state_r   <= ST_ENTRY;
                        pending_r <= 1'b0;
                        out_r     <= outs_f(ST_ENTRY, phase_r);
                    end else if (door_closed) begin
                        state_r <= ST_RUN;
                        out_r   <= outs_f(ST_RUN, phase_r);
                    end else begin
                        state_r <= ST_PAUSE;
                        out_r   <= outs_f(ST_PAUSE, phase_r);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    out_r   <= outs_f(ST_IDLE, phase_r);
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                    out_r   <= outs_f(ST_FAULT, phase_r);
                end
                default: begin
                    state_r <= ST_FAULT;
                    out_r   <= outs_f(ST_FAULT, phase_r);
                end
            endcase
        end
    end

    assign phase_sel    = out_r.phase_sel;
    assign timer_start  = out_r.timer_start;
    assign timer_enable = out_r.timer_enable;
    assign fill_valve   = out_r.fill_valve;
    assign drain_valve  = out_r.drain_valve;
    assign motor_on     = out_r.motor_on;
    assign spin_fast    = out_r.spin_fast;
    assign busy         = out_r.busy;
    assign cycle_done   = out_r.cycle_done;
    assign fault        = out_r.fault;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Testbench for wash_cycle_controller: directed scenarios plus random
// stimulus, every cycle compared against a flag-based behavioural model.
module tb_wash_cycle_controller;

    localparam int WD = 16;
`ifdef WASH_CTRL_SOAK_EN
    localparam int         NPH      = 4;
    localparam logic [1:0] FIRST_PH = 2'd0;
    localparam bit         SOAK     = 1'b1;
`else
    localparam int         NPH      = 3;
    localparam logic [1:0] FIRST_PH = 2'd1;
    localparam bit         SOAK     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start_btn, door_closed, timer_done;
    logic [1:0] phase_sel;
    logic       timer_start, timer_enable, fill_valve, drain_valve;
    logic       motor_on, spin_fast, busy, cycle_done, fault;
    logic [10:0] dut_vec;

    int tests = 0;
    int fails = 0;
    int ts_cnt = 0;

    // Behavioural model state
    bit         m_fault, m_active, m_starting, m_paused, m_pending, m_done, m_armed;
    int         m_idx, m_wd;
    logic [1:0] m_phase;

    always #5 clk = ~clk;

    wash_cycle_controller #(.WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
        .door_closed(door_closed), .timer_done(timer_done),
        .phase_sel(phase_sel), .timer_start(timer_start),
        .timer_enable(timer_enable), .fill_valve(fill_valve),
        .drain_valve(drain_valve), .motor_on(motor_on),
        .spin_fast(spin_fast), .busy(busy), .cycle_done(cycle_done),
        .fault(fault)
    );

    assign dut_vec = {phase_sel, timer_start, timer_enable, fill_valve, drain_valve,
                      motor_on, spin_fast, busy, cycle_done, fault};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_act(input logic [1:0] ph);
        case (ph)
            2'd0:    return SOAK ? 4'b1000 : 4'b0000;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b1010;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        bit live;
        logic [3:0] a;
        live = m_active && !m_paused;
        a    = live ? exp_act(m_phase) : 4'b0000;
        return {m_fault ? 2'b00 : m_phase, live && m_starting, live && !m_starting, a,
                m_active, m_done, m_fault};
    endfunction

    task model_reset();
        m_fault = 0; m_active = 0; m_starting = 0; m_paused = 0;
        m_pending = 0; m_done = 0; m_armed = 0; m_idx = 0; m_wd = 0;
        m_phase = 2'd0;
    endtask

    task model_step();
        if (m_fault) begin
            m_fault = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (!start_btn) m_armed = 1;
            else if (door_closed && m_armed) begin
                m_armed = 0; m_active = 1; m_starting = 1; m_paused = 0;
                m_idx = 0; m_phase = FIRST_PH;
            end
        end else if (m_paused) begin
            if (door_closed) begin
                m_paused = 0; m_starting = m_pending; m_pending = 0;
            end
        end else if (m_starting) begin
            m_wd = 0; m_starting = 0;
            if (!door_closed) begin m_paused = 1; m_pending = 1; end
        end else if (timer_done) begin
            if (m_idx == NPH - 1) begin
                m_active = 0; m_done = 1;
            end else begin
                m_idx++;
                m_phase = 2'(int'(FIRST_PH) + m_idx);
                if (door_closed) m_starting = 1;
                else begin m_paused = 1; m_pending = 1; end
            end
        end else if (!door_closed) begin
            m_paused = 1;
        end else begin
            m_wd++;
            if (m_wd == WD) begin m_fault = 1; m_active = 0; end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare at the negedge.
    task automatic cyc(input bit sb, input bit dc, input bit td);
        start_btn = sb; door_closed = dc; timer_done = td;
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        chk("model_compare", dut_vec, exp_vec());
        if (timer_start === 1'b1) ts_cnt++;
    endtask

    task automatic run_phase(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
    endtask

    task automatic start_cycle();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: actual still running, required finished");
        $fatal(1);
    end

    initial begin
        bit dc_r;
        rst_n = 1'b0; start_btn = 1'b0; door_closed = 1'b1; timer_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", dut_vec, 11'h000);
        rst_n = 1'b1;

        // Full cycle, door closed, 5 enabled cycles per phase
        cyc(1'b0, 1'b1, 1'b0);
        ts_cnt = 0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("first_start", {timer_start, phase_sel}, {1'b1, FIRST_PH});
        cyc(1'b0, 1'b1, 1'b0);
        chk("enable_after_start", {timer_start, timer_enable}, 2'b01);
        run_phase(4);
        for (int p = 1; p < NPH; p++) begin
            chk("phase_entry", {timer_start, phase_sel}, {1'b1, 2'(int'(FIRST_PH) + p)});
            run_phase(5);
        end
        chk("done_pulse", {busy, cycle_done}, 2'b01);
        cyc(1'b0, 1'b1, 1'b0);
        chk("done_one_cycle", {busy, cycle_done}, 2'b00);
        chk("start_pulse_count", ts_cnt, NPH);

        // Door opens during wash, closed again after 10 cycles
        start_cycle();
        if (SOAK) run_phase(5);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("door_pause", dut_vec, {2'b01, 9'b00_0000_100});
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("resume_no_start", dut_vec, {2'b01, 9'b01_0010_100});
        run_phase(2);

        // timer_done with door open in rinse
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("done_door_pause", dut_vec, {2'b11, 9'b00_0000_100});
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("spin_entry", dut_vec, {2'b11, 9'b10_0111_100});
        cyc(1'b0, 1'b1, 1'b0);
        chk("spin_run", dut_vec, {2'b11, 9'b01_0111_100});
        run_phase(3);
        chk("done_after_spin", cycle_done, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);

        // Watchdog: timer never completes
        start_cycle();
        for (int k = 0; k < WD; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("no_fault_before_limit", fault, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("fault_entered", dut_vec, 11'h001);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0);
        chk("fault_sticky", dut_vec, 11'h001);
        #1 rst_n = 1'b0; model_reset();
        #1 chk("fault_cleared_by_reset", dut_vec, 11'h000);
        cyc(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Asynchronous reset mid-spin with the button held
        start_cycle();
        for (int p = 0; p < NPH - 1; p++) run_phase(5);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("mid_spin", dut_vec, {2'b11, 9'b01_0111_100});
        start_btn = 1'b1;
        #1 rst_n = 1'b0; model_reset();
        #1 chk("async_reset", dut_vec, 11'h000);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0);
        chk("held_button_ignored", {busy, timer_start}, 2'b00);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("restart_after_release", {timer_start, phase_sel}, {1'b1, FIRST_PH});

        // Random stimulus with periodic resets
        dc_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                #1 rst_n = 1'b0; model_reset();
            end else begin
                rst_n = 1'b1;
            end
            if (dc_r) dc_r = ($urandom_range(0, 11) != 0);
            else      dc_r = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 2) == 0, dc_r, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
